sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Upstream conditioning stage for the 9 board slide switches before they reach the 8-3 priority encoder. Bit 8 is the enable; bits 7..0 are the data.
- Synchronises each raw switch bit and debounces it independently.
- Presents a stable registered switch vector, plus one-cycle rise/fall/change pulses that downstream logic can use to latch or count encoder results.

Parameters:
- WIDTH, 9, number of switch bits handled.
- STABLE_CYCLES, 16, consecutive clock cycles a synchronised bit must differ from its current debounced value before the change is accepted. Legal range is 1 to 2^CNT_W-1. Board builds override this to roughly 500000.
- CNT_W, 20, width of each per-bit stability counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  WIDTH  raw asynchronous switch levels.
- sw  out  WIDTH  debounced, registered switch levels. Bit 8 is the encoder enable; bits 7..0 are the encoder data.
- sw_rise  out  WIDTH  per-bit one-cycle pulse: the debounced bit went 0->1 this cycle.
- sw_fall  out  WIDTH  per-bit one-cycle pulse: the debounced bit went 1->0 this cycle.
- sw_chg  out  1  one-cycle pulse: OR of all bits of (sw_rise | sw_fall).

Behaviour:
- Reset: when rst=1 at a rising edge, clear all state:
  - sync1 and sync2 = 0
  - every cnt[i] = 0
  - sw, sw_rise, sw_fall = 0
  - sw_chg = 0
  - rst has priority over all other activity, including a count in progress; that count is discarded.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Two flops per bit. Only sync2 feeds the debounce logic.
- Per-bit debounce, evaluated each edge when rst=0, bits independent:
  - sync2[i] == sw[i]: cnt[i] <= 0. Any glitch shorter than the window fully restarts the count.
  - sync2[i] != sw[i] and cnt[i] != STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw[i] and cnt[i] == STABLE_CYCLES-1: sw[i] <= sync2[i]; cnt[i] <= 0; sw_rise[i] <= sync2[i]; sw_fall[i] <= ~sync2[i].
  - In every other case sw_rise[i] <= 0 and sw_fall[i] <= 0, so each pulse is exactly one cycle wide.
- Change pulse: sw_chg is registered and asserts in the same cycle as any sw_rise/sw_fall bit.
- Latency:
  - sw_raw[i] changes before edge E1 and is held. Call E1 the first edge that samples the new value.
  - sw[i] and its pulse update at edge E(STABLE_CYCLES+2): edge 18 for the default, edge 3 for STABLE_CYCLES=1.
- Bounce handling:
  - A bit that toggles back before the window completes produces no output change and no pulse.
  - A bounce that ends on the original level is invisible at the output.
- Simultaneous events:
  - Several bits may qualify on the same edge. All of them update together and sw_chg pulses once.
  - Bits with staggered timing produce separate sw_chg pulses.
- Counter wrap: cnt never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- After reset: sw reads 0 even if sw_raw is high. A held-high raw bit then produces sw_rise exactly STABLE_CYCLES+2 edges after the first edge with rst=0.
- Outputs never depend combinationally on sw_raw.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with sw_raw=9'h1FF -> sw=0, sw_rise=0, sw_fall=0, sw_chg=0 throughout. After release, sw=9'h1FF at the 18th edge, sw_rise=9'h1FF and sw_chg=1 for exactly one cycle.
- Clean press: sw_raw goes 9'h000 -> 9'h101 and is held -> sw=9'h101 at edge 18 (not 17), sw_rise=9'h101 for one cycle, sw_fall=0.
- Bounce reject: sw_raw[3] pulses high for 10 cycles, drops low for 2, then is high for 10 more -> sw[3] stays 0 and no pulses occur. Holding it high afterwards updates sw[3] 18 edges after the last rising transition.
- Release and staggered bits:
  - From sw=9'h101, drop bit 0 then, 5 cycles later, drop bit 8 -> sw_fall[0] and sw_fall[8] each pulse once, 5 cycles apart.
  - sw_chg pulses twice; final sw=0.
- Reset mid-count: raise sw_raw[7], assert rst for 1 cycle at edge 10 -> no output change at edge 18. After release, sw[7]=1 on the 18th post-reset edge.
- STABLE_CYCLES=1 build: single-cycle raw pulse on bit 2 -> sw[2]=1 at edge 3 and returns to 0 at edge 4, with sw_rise[2] then sw_fall[2] pulsing once each.

Source files
------------

// File: rtl/sw_debounce.sv
// Two-flop synchroniser and per-bit debouncer for the board slide switches.
// Produces a registered stable vector plus one-cycle rise/fall/change pulses.
module sw_debounce #(
    parameter int WIDTH         = 9,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] hit;

    // hit[i]: bit i has differed for the full window and flips on this edge
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            hit[i] = (sync2[i] != sw[i]) && (cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sw      <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            sw_chg  <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((sync2[i] == sw[i]) || hit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            sw      <= sw ^ hit;
            sw_rise <= hit & sync2;
            sw_fall <= hit & ~sync2;
            sw_chg  <= |hit;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: a timestamp-based reference model pushes
// expected outputs each edge; a negedge monitor pops and compares.
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] raw0 = '0;
    logic [8:0] raw1 = '0;
    logic [8:0] sw0, rise0, fall0;
    logic [8:0] sw1, rise1, fall1;
    logic       chg0, chg1;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(9), .STABLE_CYCLES(16), .CNT_W(20)) u0 (
        .clk(clk), .rst(rst), .sw_raw(raw0),
        .sw(sw0), .sw_rise(rise0), .sw_fall(fall0), .sw_chg(chg0)
    );

    sw_debounce #(.WIDTH(9), .STABLE_CYCLES(1), .CNT_W(20)) u1 (
        .clk(clk), .rst(rst), .sw_raw(raw1),
        .sw(sw1), .sw_rise(rise1), .sw_fall(fall1), .sw_chg(chg1)
    );

    // Reference model: per bit, remember the edge at which the synchronised
    // level started disagreeing with the output; flip once the disagreement
    // has lasted s consecutive evaluations.
    logic [8:0] m_p1 [2];
    logic [8:0] m_p2 [2];
    logic [8:0] m_sw [2];
    int         m_since [2][9];

    logic [27:0] q0 [$];
    logic [27:0] q1 [$];

    task automatic model_step(input int k, input logic r, input logic [8:0] raw,
                              input int s, output logic [27:0] e);
        logic [8:0] s2, rise, fall;
        rise = '0;
        fall = '0;
        if (r) begin
            m_p1[k] = '0;
            m_p2[k] = '0;
            m_sw[k] = '0;
            for (int i = 0; i < 9; i++) m_since[k][i] = -1;
        end else begin
            s2 = m_p2[k];
            for (int i = 0; i < 9; i++) begin
                if (s2[i] == m_sw[k][i]) begin
                    m_since[k][i] = -1;
                end else begin
                    if (m_since[k][i] < 0) m_since[k][i] = edge_n;
                    if (edge_n - m_since[k][i] + 1 >= s) begin
                        m_sw[k][i]    = s2[i];
                        rise[i]       = s2[i];
                        fall[i]       = ~s2[i];
                        m_since[k][i] = -1;
                    end
                end
            end
            m_p2[k] = m_p1[k];
            m_p1[k] = raw;
        end
        e = {m_sw[k], rise, fall, |(rise | fall)};
    endtask

    always @(posedge clk) begin
        logic [27:0] e;
        edge_n++;
        model_step(0, rst, raw0, 16, e);
        q0.push_back(e);
        model_step(1, rst, raw1, 1, e);
        q1.push_back(e);
    end

    task automatic check(input int k, input logic [27:0] exp, input logic [27:0] got);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL outputs u%0d edge %0d: got sw=%h rise=%h fall=%h chg=%b, want sw=%h rise=%h fall=%h chg=%b",
                     k, edge_n, got[27:19], got[18:10], got[9:1], got[0],
                     exp[27:19], exp[18:10], exp[9:1], exp[0]);
        end
    endtask

    always @(negedge clk) begin
        logic [27:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(0, e, {sw0, rise0, fall0, chg0});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(1, e, {sw1, rise1, fall1, chg1});
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  e;
        bit  seen;
        int unsigned b;

        // Reset held with all switches high, then measure release latency
        rst  = 1'b1;
        raw0 = 9'h1FF;
        raw1 = 9'h000;
        hold(3);
        rst  = 1'b0;
        e    = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            e++;
            #1;
            if (rise0 != '0) seen = 1'b1;
        end
        vectors++;
        if (!seen || e != 18 || rise0 !== 9'h1FF || chg0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_latency: got edge=%0d rise=%h chg=%b seen=%0d, want edge=18 rise=1ff chg=1 seen=1",
                     e, rise0, chg0, seen);
        end
        hold(5);

        raw0 = 9'h000; hold(30);
        raw0 = 9'h101; hold(30);

        raw0[3] = 1'b1; hold(10);
        raw0[3] = 1'b0; hold(2);
        raw0[3] = 1'b1; hold(30);
        raw0[3] = 1'b0; hold(30);

        raw0[0] = 1'b0; hold(5);
        raw0[8] = 1'b0; hold(30);

        raw0[7] = 1'b1; hold(9);
        rst = 1'b1; hold(1);
        rst = 1'b0; hold(30);
        raw0 = 9'h000; hold(30);

        raw1[2] = 1'b1; hold(1);
        raw1[2] = 1'b0; hold(10);
        raw1 = 9'h1A5; hold(4);
        raw1 = 9'h05A; hold(4);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7, 0) == 0) begin
                b = $urandom_range(8, 0);
                raw0[b] = ~raw0[b];
            end
            if ($urandom_range(2, 0) == 0) begin
                b = $urandom_range(8, 0);
                raw1[b] = ~raw1[b];
            end
            rst = ($urandom_range(599, 0) == 0);
            hold(1);
        end
        rst = 1'b0;
        hold(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
